fetch_unit: RTL



---
 rtl/fetch_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited in-order word fetch, PC/word buffer, decode handshake.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        fetch_misaligned
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_X = (CW + 1)'(DEPTH);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_TRAP  = 2'd3;

    logic [1:0]    state, state_nx;
    logic [31:0]   fpc, rpc;
    logic [CW-1:0] inflight, inflight_nx, count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [CW:0]   occupancy;
    logic          req_hs, rsp_take, push, pop;
    logic [31:0]   redir_target;
    logic [1:0]    redir_done_state, flush_done_state;

    // Credit check sees only registered occupancy, never this cycle's pop or response.
    assign occupancy      = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = (state == S_RUN) && (occupancy < DEPTH_X);
    assign imem_req_addr  = fpc;
    assign req_hs         = imem_req_valid && imem_req_ready;
    assign rsp_take       = imem_rsp_valid && (inflight != '0);
    assign push           = rsp_take && (state == S_RUN) && !redirect;
    assign instr_valid    = (count != '0);
    assign pop            = instr_valid && instr_ready;
    assign instruction    = instr_valid ? fifo_data[rd_ptr] : 32'h0;
    assign instr_pc       = instr_valid ? fifo_pc[rd_ptr]   : 32'h0;
    assign inflight_nx    = inflight + CW'(req_hs) - CW'(rsp_take);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic redir_mis, trap_pend;

    assign redir_mis        = (redirect_pc[1:0] != 2'b00);
    assign redir_target     = redirect_pc;
    assign redir_done_state = redir_mis ? S_TRAP : S_RUN;
    assign flush_done_state = trap_pend ? S_TRAP : S_RUN;
    assign fetch_misaligned = (state == S_TRAP);

    // Remembers where a flush lands once the stale responses have drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            trap_pend <= 1'b0;
        else if (redirect)
            trap_pend <= redir_mis;
    end
`else
    assign redir_target     = redirect_pc & 32'hFFFF_FFFC;
    assign redir_done_state = S_RUN;
    assign flush_done_state = S_RUN;
    assign fetch_misaligned = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_BOOT:  state_nx = S_RUN;
            S_FLUSH: if (inflight_nx == '0) state_nx = flush_done_state;
            default: state_nx = state;
        endcase
        if (redirect)
            state_nx = (inflight_nx != '0) ? S_FLUSH : redir_done_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_BOOT;
            fpc      <= RESET_PC;
            rpc      <= RESET_PC;
            inflight <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state    <= state_nx;
            inflight <= inflight_nx;
            if (redirect) begin
                fpc    <= redir_target;
                rpc    <= redir_target;
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (req_hs)
                    fpc <= fpc + 32'd4;
                if (push) begin
                    rpc    <= rpc + 32'd4;
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Buffer storage carries no reset; outputs are gated by instr_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= rpc;
            fifo_data[wr_ptr] <= imem_rsp_data;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == DEPTH_C)));

endmodule
